// File: rtl/sram_rd_streamer.sv
// Strided SRAM read initiator: issues reads on one SRAM port and streams the words out
// through a 2-entry skid FIFO. Define SRD_STALL_CNT_EN to build the back-pressure stall counter.
module sram_rd_streamer #(
  parameter int DEPTH  = 4096,
  parameter int WIDTH  = 8,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int LEN_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_base,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic [ADDR_W-1:0] cmd_stride,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [WIDTH-1:0]  mem_dout,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_data,
  output logic              out_last,
  output logic              busy,
  output logic              done,
  output logic [31:0]       stall_cnt
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t state, state_nx;

  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] stride_q;
  logic [LEN_W-1:0]  rem_q;
  logic              pend_q;
  logic              pend_last_q;
  logic [WIDTH:0]    fifo_q [2];
  logic              wr_ptr_q;
  logic              rd_ptr_q;
  logic [1:0]        cnt_q;

  logic             accept;
  logic             issue;
  logic             fifo_empty;
  logic             valid_int;
  logic             hs;
  logic             bypass;
  logic             enq;
  logic             deq_fifo;
  logic [WIDTH-1:0] head_data;
  logic             head_last;

  assign accept     = (state == IDLE) && cmd_valid;
  assign fifo_empty = (cnt_q == 2'd0);
  assign issue      = (state == ISSUE) && (({1'b0, cnt_q} + {2'b00, pend_q}) < 3'd2);

  // The word returning from the SRAM is presented directly when the FIFO is empty,
  // and is only written into the FIFO if it is not consumed in that same cycle.
  assign valid_int = !fifo_empty || pend_q;
  assign head_data = fifo_empty ? mem_dout    : fifo_q[rd_ptr_q][WIDTH-1:0];
  assign head_last = fifo_empty ? pend_last_q : fifo_q[rd_ptr_q][WIDTH];
  assign hs        = valid_int && out_ready;
  assign bypass    = fifo_empty && pend_q && out_ready;
  assign enq       = pend_q && !bypass;
  assign deq_fifo  = !fifo_empty && out_ready;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    cmd_ready = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE:    if (cmd_valid) state_nx = (cmd_len == '0) ? DONE : ISSUE;
      ISSUE:   if (issue && (rem_q == LEN_W'(1))) state_nx = DRAIN;
      DRAIN:   if (hs && head_last) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (!rst) begin
      cmd_ready = (state == IDLE);
      busy      = (state != IDLE);
      done      = (state == DONE);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q      <= '0;
      stride_q    <= '0;
      rem_q       <= '0;
      pend_q      <= 1'b0;
      pend_last_q <= 1'b0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      cnt_q       <= '0;
    end else begin
      if (accept) begin
        addr_q   <= cmd_base;
        rem_q    <= cmd_len;
        stride_q <= cmd_stride;
      end else if (issue) begin
        addr_q <= addr_q + stride_q;
        rem_q  <= rem_q - LEN_W'(1);
      end
      pend_q <= issue;
      if (issue) pend_last_q <= (rem_q == LEN_W'(1));
      if (enq) wr_ptr_q <= ~wr_ptr_q;
      if (deq_fifo) rd_ptr_q <= ~rd_ptr_q;
      cnt_q <= cnt_q + {1'b0, enq} - {1'b0, deq_fifo};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && enq) fifo_q[wr_ptr_q] <= {pend_last_q, mem_dout};
  end

  assign mem_en    = issue && !rst;
  assign mem_we    = 1'b0;
  assign mem_addr  = mem_en ? addr_q : '0;
  assign out_valid = valid_int && !rst;
  assign out_data  = out_valid ? head_data : '0;
  assign out_last  = out_valid && head_last;

`ifdef SRD_STALL_CNT_EN
  logic [31:0] stall_q;

  always_ff @(posedge clk) begin
    if (rst || accept) stall_q <= '0;
    else if (valid_int && !out_ready && (stall_q != '1)) stall_q <= stall_q + 32'd1;
  end

  assign stall_cnt = rst ? '0 : stall_q;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_sram_rd_streamer.sv
// Self-checking bench for sram_rd_streamer: SRAM model, command-level reference queues,
// and a per-cycle compare process sampling on the falling edge.
module tb_sram_rd_streamer;
  localparam int DEPTH  = 4096;
  localparam int WIDTH  = 8;
  localparam int ADDR_W = 12;
  localparam int LEN_W  = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic [ADDR_W-1:0] cmd_base = '0;
  logic [LEN_W-1:0]  cmd_len = '0;
  logic [ADDR_W-1:0] cmd_stride = '0;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [WIDTH-1:0]  mem_dout;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [WIDTH-1:0]  out_data;
  logic              out_last;
  logic              busy;
  logic              done;
  logic [31:0]       stall_cnt;

  sram_rd_streamer #(.DEPTH(DEPTH), .WIDTH(WIDTH), .ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_base(cmd_base), .cmd_len(cmd_len), .cmd_stride(cmd_stride),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_dout(mem_dout),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .busy(busy), .done(done), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  logic [WIDTH-1:0] sram [DEPTH];
  initial for (int i = 0; i < DEPTH; i++) sram[i] = WIDTH'(i);
  always @(posedge clk) if (mem_en) mem_dout <= sram[mem_addr];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: what the command must produce, from address arithmetic and memory contents.
  logic [ADDR_W-1:0] exp_addr[$];
  logic [WIDTH:0]    exp_beat[$];

  function automatic void model_cmd(input logic [ADDR_W-1:0] base, input int len,
                                    input logic [ADDR_W-1:0] stride);
    exp_addr.delete();
    exp_beat.delete();
    for (int k = 0; k < len; k++) begin
      logic [ADDR_W-1:0] a;
      logic lst;
      a   = ADDR_W'(int'(base) + k * int'(stride));
      lst = (k == len - 1);
      exp_addr.push_back(a);
      exp_beat.push_back({lst, sram[a]});
    end
  endfunction

  int acc_cyc = 0;
  int first_issue, first_beat, last_beat, done_cyc;
  int beats, issues, busy_cycles, valid_cycles, stall_seen;
  int outstanding = 0;
  logic [ADDR_W-1:0] addr_log[$];
  logic [WIDTH:0]    beat_log[$];
  bit             prev_stall = 1'b0;
  logic [WIDTH:0] prev_beat = '0;

  function automatic void clear_stats();
    first_issue = -1; first_beat = -1; last_beat = -1; done_cyc = -1;
    beats = 0; issues = 0; busy_cycles = 0; valid_cycles = 0; stall_seen = 0;
    addr_log.delete();
    beat_log.delete();
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      chk("reset_outputs", {cmd_ready, mem_en, mem_we, out_valid, out_last, busy, done, mem_addr, out_data}, 0);
      chk("reset_stall_cnt", stall_cnt, 0);
      exp_addr.delete();
      exp_beat.delete();
      outstanding = 0;
      prev_stall  = 1'b0;
    end else begin
      chk("mem_we_zero", mem_we, 0);
      if (busy) busy_cycles++;
      if (out_valid) valid_cycles++;
      if (prev_stall) chk("stall_hold", {out_valid, out_last, out_data}, {1'b1, prev_beat});
      if (mem_en) begin
        issues++;
        if (first_issue < 0) first_issue = cyc - acc_cyc;
        chk("issue_window_lt2", (outstanding < 2), 1);
        if (exp_addr.size() == 0) chk("issue_expected", exp_addr.size(), 1);
        else chk("mem_addr", mem_addr, exp_addr.pop_front());
        addr_log.push_back(mem_addr);
      end
      if (out_valid && out_ready) begin
        beats++;
        if (first_beat < 0) first_beat = cyc - acc_cyc;
        if (out_last) last_beat = cyc - acc_cyc;
        beat_log.push_back({out_last, out_data});
        if (exp_beat.size() == 0) chk("beat_expected", exp_beat.size(), 1);
        else chk("beat", {out_last, out_data}, exp_beat.pop_front());
      end
      if (out_valid && !out_ready) stall_seen++;
      if (done) done_cyc = cyc - acc_cyc;
      outstanding += int'(mem_en) - int'(out_valid && out_ready);
      prev_stall = out_valid && !out_ready;
      prev_beat  = {out_last, out_data};
    end
  end

  bit pat [8] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

  task automatic run_cmd(input logic [ADDR_W-1:0] base, input logic [LEN_W-1:0] len,
                         input logic [ADDR_W-1:0] stride, input bit use_pat);
    bit accepted = 1'b0;
    bit got_done = 1'b0;
    int pidx = 0;
    model_cmd(base, int'(len), stride);
    for (int n = 0; n < 300 && !got_done; n++) begin
      @(posedge clk); #1;
      cmd_valid  = !accepted;
      cmd_base   = base;
      cmd_len    = len;
      cmd_stride = stride;
      out_ready  = use_pat ? pat[pidx % 8] : 1'b1;
      if (accepted) pidx++;
      @(negedge clk); #1;
      if (!accepted && cmd_valid && cmd_ready) begin
        accepted = 1'b1;
        acc_cyc  = cyc;
        clear_stats();
      end else if (accepted && done) begin
        got_done = 1'b1;
      end
    end
    chk("done_within_budget", got_done, 1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    out_ready = 1'b1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    clear_stats();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk); #1;
    chk("post_reset_cmd_ready", cmd_ready, 1);
    chk("post_reset_outputs", {mem_en, mem_we, out_valid, out_last, busy, done, mem_addr, out_data, stall_cnt}, 0);

    // Basic read with exact cycle positions.
    run_cmd(12'h010, 16'd4, 12'd1, 1'b0);
    chk("basic_first_issue_cycle", first_issue, 1);
    chk("basic_first_beat_cycle", first_beat, 2);
    chk("basic_last_beat_cycle", last_beat, 5);
    chk("basic_done_cycle", done_cyc, 6);
    chk("basic_beats", beats, 4);
    chk("basic_addr0", addr_log[0], 12'h010);
    chk("basic_addr3", addr_log[3], 12'h013);
    chk("basic_beat0", beat_log[0], {1'b0, 8'h10});
    chk("basic_beat2", beat_log[2], {1'b0, 8'h12});
    chk("basic_beat3", beat_log[3], {1'b1, 8'h13});
    @(negedge clk); #1;
    chk("basic_cmd_ready_after_done", cmd_ready, 1);
    chk("basic_idle_after_done", busy, 0);

    // Back-pressure pattern.
    run_cmd(12'h100, 16'd8, 12'd1, 1'b1);
    chk("bp_beats", beats, 8);
    chk("bp_issues", issues, 8);
    chk("bp_stalls_observed", (stall_seen > 0), 1);
    chk("bp_last_beat", beat_log[7], {1'b1, 8'h07});
`ifdef SRD_STALL_CNT_EN
    chk("bp_stall_cnt", stall_cnt, stall_seen);
    @(negedge clk); #1;
    chk("bp_stall_cnt_hold", stall_cnt, stall_seen);
`else
    chk("bp_stall_cnt_tied", stall_cnt, 0);
`endif

    // Address wrap.
    run_cmd(12'hFFE, 16'd4, 12'd1, 1'b0);
    chk("wrap_addr0", addr_log[0], 12'hFFE);
    chk("wrap_addr1", addr_log[1], 12'hFFF);
    chk("wrap_addr2", addr_log[2], 12'h000);
    chk("wrap_addr3", addr_log[3], 12'h001);
    chk("wrap_beat2", beat_log[2], {1'b0, 8'h00});

    // Non-unit stride.
    run_cmd(12'd5, 16'd3, 12'd3, 1'b0);
    chk("stride_addr1", addr_log[1], 12'd8);
    chk("stride_addr2", addr_log[2], 12'd11);
    chk("stride_beat0", beat_log[0], {1'b0, 8'h05});
    chk("stride_beat2", beat_log[2], {1'b1, 8'h0B});

    // Zero stride under back-pressure.
    run_cmd(12'h0AB, 16'd3, 12'd0, 1'b1);
    chk("stride0_addr2", addr_log[2], 12'h0AB);
    chk("stride0_beats", beats, 3);

    // Zero length.
    run_cmd(12'h300, 16'd0, 12'd1, 1'b0);
    chk("zero_done_cycle", done_cyc, 1);
    chk("zero_busy_cycles", busy_cycles, 1);
    chk("zero_issues", issues, 0);
    chk("zero_valid_cycles", valid_cycles, 0);

    // Reset in the middle of a command.
    model_cmd(12'h040, 6, 12'd1);
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_base = 12'h040; cmd_len = 16'd6; cmd_stride = 12'd1; out_ready = 1'b1;
    @(negedge clk); #1;
    chk("midrst_accept_ready", cmd_ready, 1);
    acc_cyc = cyc;
    clear_stats();
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    n = 0;
    while (beats < 2 && n < 50) begin
      @(negedge clk); #1;
      n++;
    end
    chk("midrst_two_beats", beats, 2);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk); #1;
    chk("midrst_cmd_ready", cmd_ready, 1);
    chk("midrst_outputs", {mem_en, out_valid, out_last, busy, done, mem_addr, out_data, stall_cnt}, 0);
    run_cmd(12'h020, 16'd2, 12'd1, 1'b0);
    chk("midrst_beats", beats, 2);
    chk("midrst_beat0", beat_log[0], {1'b0, 8'h20});
    chk("midrst_beat1", beat_log[1], {1'b1, 8'h21});
    repeat (4) @(negedge clk);
    #1;
    chk("final_no_stray_beats", beats, 2);
    chk("final_addr_queue_empty", exp_addr.size(), 0);
    chk("final_beat_queue_empty", exp_beat.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
